instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of pc and ld_addr.
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 64, number of words; power of two, 4..4096.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra fetch latency cycles; range 0..15.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req, input, 1, fetch request, sampled only in IDLE.
REQ-008 SHALL have port pc, input, ADDR_W, byte address of fetch, sampled with req.
REQ-009 SHALL have port instruction, output, DATA_W, fetched word, registered.
REQ-010 SHALL have port valid, output, 1, one-cycle pulse marking instruction/fault updated.
REQ-011 SHALL have port busy, output, 1, high while a fetch is in flight.
REQ-012 SHALL have port fault, output, 1, high with valid when fetch address was illegal.
REQ-013 SHALL have port ld_en, input, 1, program-load write strobe.
REQ-014 SHALL have port ld_addr, input, ADDR_W, byte address of load word.
REQ-015 SHALL have port ld_data, input, DATA_W, load word.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 IDLE: req=1 SHALL capture pc, load wait counter with WAIT_STATES, go to WAIT if WAIT_STATES>0 else RESP; req=0 stays IDLE.
REQ-018 WAIT: counter SHALL decrement each cycle; on reaching 0 go to RESP.
REQ-019 RESP: SHALL drive valid=1 for exactly one cycle, update instruction and fault, return to IDLE.
REQ-020 Latency SHALL be WAIT_STATES+1 cycles: req sampled at edge N -> valid high after edge N+WAIT_STATES+1.
REQ-021 busy SHALL be high in WAIT and RESP, low in IDLE; req while busy SHALL be ignored, not queued.
REQ-022 Back-to-back: req high in the cycle valid is high SHALL NOT be accepted; next acceptance earliest one cycle after valid.
REQ-023 Word index SHALL be pc[log2(DEPTH)+1:2].
REQ-024 Illegal address: pc[1:0]!=0 or pc >= 4*DEPTH SHALL set fault=1 and instruction=0 at RESP, memory not read.
REQ-025 Legal address SHALL set fault=0 and instruction=mem[index] read in RESP cycle.
REQ-026 instruction and fault SHALL hold their values between valid pulses.
REQ-027 ld_en=1 with legal, aligned ld_addr SHALL write ld_data to mem[index] at that edge, in any FSM state.
REQ-028 ld_en with illegal ld_addr SHALL be ignored, no write, no fault.
REQ-029 Load and RESP read of same word in same cycle SHALL return the old word (read-before-write).
REQ-030 Load to the in-flight word before RESP SHALL be returned by that fetch.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE, counter=0, instruction=0, valid=0, busy=0, fault=0.
REQ-032 Reset mid-fetch SHALL abort it; no valid pulse SHALL follow for the aborted request.
REQ-033 Memory contents SHALL NOT be altered by reset; ld_en SHALL be ignored while rst=0.
REQ-034 req sampled during reset SHALL be discarded.

Verification
REQ-035 WAIT_STATES=0: load 0x20100005 at 0x00, 0x8C220004 at 0x04; req pc=0x00 -> valid next cycle, instruction=0x20100005, fault=0; req pc=0x04 -> 0x8C220004.
REQ-036 WAIT_STATES=2: req pc=0x04 at edge N -> busy edges N+1..N+3, valid only after edge N+3, instruction=0x8C220004; req held high during busy not accepted.
REQ-037 Faults, DEPTH=64: pc=0x06 -> valid, fault=1, instruction=0; pc=0x100 -> fault=1; pc=0xFC -> fault=0.
REQ-038 WAIT_STATES=3: assert rst=0 one cycle after req pc=0x00 -> outputs zero, no valid for 8 cycles after release; memory word 0x00 still 0x20100005 on next fetch.
REQ-039 WAIT_STATES=0: ld_en at 0x08 with 0xDEADBEEF same cycle as RESP for pc=0x08 (old 0x00000000) -> instruction=0x00000000; refetch -> 0xDEADBEEF.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// Instruction memory with a single-outstanding fetch port and a program-load write port.
// Fetch latency is WAIT_STATES+1 cycles; requests arriving while busy or during the valid cycle are dropped.
module instr_fetch_mem #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              valid,
    output logic              busy,
    output logic              fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              fault_q, fault_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Misaligned or beyond the last word; shift avoids a 4*DEPTH constant wider than ADDR_W.
    function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != '0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (req && !valid_q) begin
                    pc_d    = pc;
                    cnt_d   = 4'(WAIT_STATES);
                    busy_d  = 1'b1;
                    state_d = (WAIT_STATES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (addr_illegal(pc_q)) begin
                    instr_d = '0;
                    fault_d = 1'b1;
                end else begin
                    instr_d = mem[pc_q[IDX_W+1:2]];
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    // Memory is never cleared; a load landing on the RESP edge is seen only by later fetches.
    always_ff @(posedge clk) begin
        if (rst && ld_en && !addr_illegal(ld_addr)) begin
            mem[ld_addr[IDX_W+1:2]] <= ld_data;
        end
    end

    assign instruction = instr_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: three instances (0, 2 and 3 wait states) share clock, reset and load bus.
module tb_instr_fetch_mem;

    localparam int WS0 = 0;
    localparam int WS1 = 2;
    localparam int WS2 = 3;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        req_v   [3];
    logic [31:0] pc_v    [3];
    logic [31:0] instr_v [3];
    logic        valid_v [3];
    logic        busy_v  [3];
    logic        fault_v [3];

    int checks = 0;
    int errors = 0;

    instr_fetch_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(WS0)) u_ws0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .pc(pc_v[0]), .instruction(instr_v[0]),
        .valid(valid_v[0]), .busy(busy_v[0]), .fault(fault_v[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    instr_fetch_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(WS1)) u_ws2 (
        .clk(clk), .rst(rst), .req(req_v[1]), .pc(pc_v[1]), .instruction(instr_v[1]),
        .valid(valid_v[1]), .busy(busy_v[1]), .fault(fault_v[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    instr_fetch_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .WAIT_STATES(WS2)) u_ws3 (
        .clk(clk), .rst(rst), .req(req_v[2]), .pc(pc_v[2]), .instruction(instr_v[2]),
        .valid(valid_v[2]), .busy(busy_v[2]), .fault(fault_v[2]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flt;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic fetch(input int k, input logic [31:0] a, input logic [31:0] ei, input logic ef);
        int n;
        int ws;
        ws = (k == 0) ? WS0 : (k == 1) ? WS1 : WS2;
        req_v[k] = 1'b1;
        pc_v[k]  = a;
        tick();
        req_v[k] = 1'b0;
        chk($sformatf("i%0d pc=%h busy_on_accept", k, a), 32'(busy_v[k]), 32'd1);
        n = 0;
        while (!valid_v[k] && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("i%0d pc=%h latency", k, a), n, ws + 1);
        chk($sformatf("i%0d pc=%h instr", k, a), instr_v[k], ei);
        chk($sformatf("i%0d pc=%h fault", k, a), 32'(fault_v[k]), 32'(ef));
        chk($sformatf("i%0d pc=%h busy_at_valid", k, a), 32'(busy_v[k]), 32'd0);
        tick();
    endtask

    initial begin
        logic saw_valid;

        vecs[0] = '{32'h0000_0000, 32'h2010_0005, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h8C22_0004, 1'b0};
        vecs[2] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0100, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_00FC, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{32'h0000_0008, 32'h0000_0000, 1'b0};
        vecs[6] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

        rst = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = 1'b0;
            pc_v[k]  = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("i%0d reset instr", k), instr_v[k], 32'd0);
            chk($sformatf("i%0d reset flags", k),
                {29'd0, valid_v[k], busy_v[k], fault_v[k]}, 32'd0);
        end
        rst = 1'b1;
        tick();

        // Illegal loads alias word 1 and must be dropped.
        load(32'h0000_0000, 32'h2010_0005);
        load(32'h0000_0004, 32'h8C22_0004);
        load(32'h0000_0008, 32'h0000_0000);
        load(32'h0000_00FC, 32'h0BAD_F00D);
        load(32'h0000_0104, 32'hFFFF_FFFF);
        load(32'h0000_0005, 32'h1111_1111);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                fetch(k, vecs[i].pc, vecs[i].instr, vecs[i].flt);
            end
        end

        // Outputs hold between pulses.
        tick();
        tick();
        chk("hold instr", instr_v[0], 32'hFFFF_FFFC & 32'h0);
        chk("hold fault", 32'(fault_v[0]), 32'd1);

        // Two wait states, req held high through busy and the valid cycle.
        req_v[1] = 1'b1;
        pc_v[1]  = 32'h0000_0004;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("ws2 busy cycle %0d", c), {30'd0, busy_v[1], valid_v[1]}, 32'd2);
            tick();
        end
        chk("ws2 valid", {30'd0, valid_v[1], busy_v[1]}, 32'd2);
        chk("ws2 instr", instr_v[1], 32'h8C22_0004);
        tick();
        chk("ws2 req in valid cycle ignored", {30'd0, busy_v[1], valid_v[1]}, 32'd0);
        req_v[1] = 1'b0;
        tick();
        chk("ws2 no queued fetch", {30'd0, busy_v[1], valid_v[1]}, 32'd0);

        // Three wait states, reset one cycle after acceptance; load and req during reset are dropped.
        req_v[2] = 1'b1;
        pc_v[2]  = 32'h0000_0000;
        tick();
        req_v[2] = 1'b0;
        tick();
        rst      = 1'b0;
        ld_en    = 1'b1;
        ld_addr  = 32'h0000_0000;
        ld_data  = 32'hFFFF_FFFF;
        req_v[2] = 1'b1;
        tick();
        chk("abort instr", instr_v[2], 32'd0);
        chk("abort flags", {29'd0, valid_v[2], busy_v[2], fault_v[2]}, 32'd0);
        rst      = 1'b1;
        ld_en    = 1'b0;
        req_v[2] = 1'b0;
        tick();
        chk("req during reset discarded", 32'(busy_v[2]), 32'd0);
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (valid_v[2]) saw_valid = 1'b1;
            tick();
        end
        chk("no valid after abort", 32'(saw_valid), 32'd0);
        fetch(2, 32'h0000_0000, 32'h2010_0005, 1'b0);

        // Load coinciding with the RESP edge returns the old word.
        req_v[0] = 1'b1;
        pc_v[0]  = 32'h0000_0008;
        tick();
        req_v[0] = 1'b0;
        ld_en    = 1'b1;
        ld_addr  = 32'h0000_0008;
        ld_data  = 32'hDEAD_BEEF;
        tick();
        ld_en    = 1'b0;
        chk("rbw valid", 32'(valid_v[0]), 32'd1);
        chk("rbw old word", instr_v[0], 32'h0000_0000);
        tick();
        fetch(0, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);

        // A load landing while the fetch waits is returned by that fetch.
        req_v[1] = 1'b1;
        pc_v[1]  = 32'h0000_00FC;
        tick();
        req_v[1] = 1'b0;
        load(32'h0000_00FC, 32'h1234_5678);
        tick();
        tick();
        chk("inflight load valid", 32'(valid_v[1]), 32'd1);
        chk("inflight load instr", instr_v[1], 32'h1234_5678);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
